// File: rtl/counter_pkg.sv
// Shared constants and direction encoding for the reversible counter family.
package counter_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SLICE_W = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

endpackage

// File: rtl/rev_slice.sv
// 4-bit reversible, loadable counter slice with async clear and carry/borrow chaining.
module rev_slice
  import counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               load,
  input  logic [SLICE_W-1:0] d,
  input  logic               ci,
  output logic [SLICE_W-1:0] q,
  output logic               co
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (ci) begin
      q <= up ? q + SLICE_W'(1) : q - SLICE_W'(1);
    end
  end

  // Carry out when this slice is at its terminal value in the current direction.
  assign co = ci & (up ? (q == {SLICE_W{1'b1}}) : (q == {SLICE_W{1'b0}}));

endmodule

// File: rtl/counter_32_rev.sv
// 32-bit reversible counter with parallel load, built from cascaded rev_slice instances.
// Optional saturation at the terminal count is enabled by defining COUNTER_32_REV_SAT_EN.
module counter_32_rev
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_W,
  parameter int unsigned SLICE_W = counter_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             Load,
  input  logic [WIDTH-1:0] PData,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  logic              up;
  logic [NSLICE:0]   carry;
  logic              slice_load;
  logic [WIDTH-1:0]  slice_d;

  assign up       = (dir_t'(s) == DIR_UP);
  assign carry[0] = 1'b1;
  assign Rc       = carry[NSLICE];

`ifdef COUNTER_32_REV_SAT_EN
  // At the terminal count, reload the current value so the counter holds.
  logic hold;
  assign hold       = Rc & ~Load;
  assign slice_load = Load | hold;
  assign slice_d    = Load ? PData : cnt;
`else
  assign slice_load = Load;
  assign slice_d    = PData;
`endif

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    rev_slice u_slice (
      .clk  (clk),
      .rst  (rst),
      .up   (up),
      .load (slice_load),
      .d    (slice_d[i*SLICE_W +: SLICE_W]),
      .ci   (carry[i]),
      .q    (cnt[i*SLICE_W +: SLICE_W]),
      .co   (carry[i+1])
    );
  end

endmodule

// File: tb/tb_counter_32_rev.sv
// Self-checking bench for counter_32_rev: arithmetic reference model plus directed literal checks.
module tb_counter_32_rev;

  logic        clk;
  logic        rst;
  logic        s;
  logic        Load;
  logic [31:0] PData;
  logic [31:0] cnt;
  logic        Rc;

  int total;
  int bad;

  logic [31:0] exp_cnt;

  counter_32_rev dut (
    .clk   (clk),
    .rst   (rst),
    .s     (s),
    .Load  (Load),
    .PData (PData),
    .cnt   (cnt),
    .Rc    (Rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on a 32-bit value.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_cnt <= 32'h0;
    end else if (Load) begin
      exp_cnt <= PData;
    end else if (s) begin
`ifdef COUNTER_32_REV_SAT_EN
      exp_cnt <= (exp_cnt == 32'hFFFF_FFFF) ? exp_cnt : exp_cnt + 32'd1;
`else
      exp_cnt <= exp_cnt + 32'd1;
`endif
    end else begin
`ifdef COUNTER_32_REV_SAT_EN
      exp_cnt <= (exp_cnt == 32'h0) ? exp_cnt : exp_cnt - 32'd1;
`else
      exp_cnt <= exp_cnt - 32'd1;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Compare DUT against the model; called once per clock cycle.
  task automatic check_model();
    logic exp_rc;
    exp_rc = s ? (exp_cnt == 32'hFFFF_FFFF) : (exp_cnt == 32'h0);
    chk("model_cnt", cnt, exp_cnt);
    chk("model_rc", 32'(Rc), 32'(exp_rc));
  endtask

  // One clock edge, then sample 1ns later and compare against the model.
  task automatic step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    s     = 1'b0;
    Load  = 1'b0;
    PData = 32'h0;

    // Reset value and same-cycle Rc response to s
    #3;
    chk("rst_cnt", cnt, 32'h0);
    chk("rst_rc_down", 32'(Rc), 32'd1);
    s = 1'b1;
    #1;
    chk("rst_rc_up", 32'(Rc), 32'd0);
    Load  = 1'b1;
    PData = 32'hDEAD_BEEF;
    step();
    step();
    chk("rst_overrides_load", cnt, 32'h0);

    // Load zero, then count down through the wrap
    rst   = 1'b0;
    Load  = 1'b1;
    PData = 32'h0;
    s     = 1'b0;
    step();
    chk("load0_cnt", cnt, 32'h0);
    chk("load0_rc", 32'(Rc), 32'd1);
    Load = 1'b0;
    step();
`ifdef COUNTER_32_REV_SAT_EN
    chk("down_sat", cnt, 32'h0);
    Load  = 1'b1;
    PData = 32'h0000_0002;
    step();
    Load = 1'b0;
    step();
    chk("down_1", cnt, 32'h0000_0001);
    chk("down_1_rc", 32'(Rc), 32'd0);
`else
    chk("down_wrap", cnt, 32'hFFFF_FFFF);
    chk("down_wrap_rc", 32'(Rc), 32'd0);
    step();
    chk("down_fffe", cnt, 32'hFFFF_FFFE);
`endif

    // Up-count at the top terminal
    Load  = 1'b1;
    PData = 32'hFFFF_FFFE;
    s     = 1'b1;
    step();
    Load = 1'b0;
    step();
    chk("up_max", cnt, 32'hFFFF_FFFF);
    chk("up_max_rc", 32'(Rc), 32'd1);
    step();
`ifdef COUNTER_32_REV_SAT_EN
    chk("up_sat", cnt, 32'hFFFF_FFFF);
    chk("up_sat_rc", 32'(Rc), 32'd1);
`else
    chk("up_wrap", cnt, 32'h0);
    chk("up_wrap_rc", 32'(Rc), 32'd0);
`endif

    // Cross-slice carry and borrow
    Load  = 1'b1;
    PData = 32'h0000_FFFF;
    step();
    Load = 1'b0;
    step();
    chk("carry_up", cnt, 32'h0001_0000);
    s = 1'b0;
    step();
    chk("borrow_down", cnt, 32'h0000_FFFF);

    // Load priority at the terminal count
    Load  = 1'b1;
    PData = 32'hFFFF_FFFF;
    step();
    s = 1'b1;
    #1;
    chk("term_rc", 32'(Rc), 32'd1);
    PData = 32'h1234_5678;
    step();
    chk("load_prio", cnt, 32'h1234_5678);
    chk("load_prio_rc", 32'(Rc), 32'd0);

    // Direction change takes effect on the next edge
    Load  = 1'b1;
    PData = 32'h0000_0003;
    step();
    Load = 1'b0;
    step();
    step();
    chk("up_5", cnt, 32'h0000_0005);
    s = 1'b0;
    step();
    chk("dir_change", cnt, 32'h0000_0004);
    s = 1'b1;
    step();
    chk("dir_back", cnt, 32'h0000_0005);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", cnt, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("resume_1", cnt, 32'h0000_0001);
    step();
    chk("resume_2", cnt, 32'h0000_0002);
    s = 1'b0;
    step();
    step();
    chk("back_to_0", cnt, 32'h0);
    chk("back_to_0_rc", 32'(Rc), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
